fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmit stage that drains the 8-bit FIFO and emits each byte as an asynchronous serial frame: one start bit (0), eight data bits LSB first, one stop bit (1). It sits directly downstream of the FIFO, watching its `empty` flag and pulsing its `read` strobe once per byte. It free-runs whenever the FIFO holds data and `enable` is high.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be ≥ 2; bit counter width is `$clog2(CLKS_PER_BIT)`.

**Ports**
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: permits starting a new frame; never aborts a frame in progress.
- `fifoEmpty` in 1: FIFO `empty` flag.
- `fifoData` in 8: FIFO `dataOut`; valid from the edge following a `read` cycle.
- `fifoRead` out 1: FIFO `read` strobe; one-cycle pulse per byte.
- `txOut` out 1: serial line; idles high.
- `busy` out 1: high whenever the state is not IDLE.
- `frameDone` out 1: one-cycle pulse after each completed stop bit.

## Operation

**States:** IDLE, FETCH, LOAD, START, DATA, STOP. All outputs are registered or Moore-decoded from state; nothing depends combinationally on inputs.

**Transitions**
- **IDLE:** `txOut`=1. If `enable`=1 and `fifoEmpty`=0 at an edge, go to FETCH.
- **FETCH:** `fifoRead`=1 for exactly this one cycle; `txOut`=1. Next state is LOAD.
- **LOAD:** `txOut`=1. At the end-of-cycle edge, capture `shiftReg <= fifoData` and go to START.
- **START:** `txOut`=0 for `CLKS_PER_BIT` cycles, then go to DATA with `bitIdx`=0.
- **DATA:** `txOut`=`shiftReg[bitIdx]` for `CLKS_PER_BIT` cycles per bit. `bitIdx` increments 0→7; after bit 7, go to STOP.
- **STOP:** `txOut`=1 for `CLKS_PER_BIT` cycles. At the final edge, `frameDone`<=1 for the next cycle. The next state is FETCH if `enable`=1 and `fifoEmpty`=0, otherwise IDLE.

**Counter rules**
- The bit-cycle counter runs 0..`CLKS_PER_BIT`-1 and resets on every state change.
- `bitIdx` is 3 bits and does not wrap past 7; its terminal value is 7.

**Boundary conditions**
- `fifoEmpty` and `enable` are sampled only in IDLE and on the last cycle of STOP. Changes during FETCH through STOP are ignored.
- A read is never issued while `fifoEmpty` is sampled high, so the FIFO never sees a read while empty.
- Dropping `enable` mid-frame lets the current frame finish, then the block goes to IDLE.
- On reset mid-operation (`rst_n` low), the block immediately forces the reset values below. The in-flight byte is discarded and not retransmitted.
- The FIFO `write` port is independent of this block, so simultaneous FIFO write and read are permitted.

## Timing

**Reset values:** state IDLE, `txOut`=1, `fifoRead`=0, `busy`=0, `frameDone`=0, `shiftReg`=0, counters 0.

**Latency**
- From the IDLE edge that samples non-empty to the first cycle of the start bit: 2 cycles (FETCH, LOAD).
- Frame length from START entry to STOP exit: 10×`CLKS_PER_BIT` cycles.

**Back-to-back frames:** the gap between the last stop-bit cycle and the next start bit is exactly 2 high cycles. Throughput is one byte per 10×`CLKS_PER_BIT`+2 cycles.

**Output timing**
- `busy` rises in the FETCH cycle and falls on entry to IDLE.
- `frameDone` coincides with the first FETCH or IDLE cycle after STOP.

## Test plan

All scenarios use `CLKS_PER_BIT`=4.

1. **Reset.** Hold `rst_n`=0 with `fifoEmpty`=0 → `txOut`=1, `fifoRead`=0, `busy`=0, `frameDone`=0 throughout. Assert reset mid-DATA → `txOut`=1 asynchronously, before the next edge.
2. **Single byte.** FIFO with 0xA5, `enable`=1 → one `fifoRead` pulse. `txOut` then shows 0×4 (start), data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1×4 (stop). One `frameDone` pulse, then IDLE with `busy`=0.
3. **Back-to-back.** FIFO with 0x01, 0x03, 0x02 → exactly 3 `fifoRead` pulses and 3 frames carrying those bytes in order. 2-cycle high gap between frames; 3 `frameDone` pulses; final state IDLE.
4. **Enable gating.** `enable`=0 with the FIFO non-empty → no `fifoRead` and `txOut`=1 for 100 cycles. Drop `enable` mid-DATA with 2 bytes queued → the current frame completes, no further read, IDLE.
5. **Reset recovery.** Assert `rst_n` during data bit 3 of 0x55, release with the FIFO still non-empty → the next frame starts 2 cycles after the first post-reset edge. That frame carries the next FIFO byte; 0x55 is not resent.
6. **Empty toggling.** Toggle `fifoEmpty` every cycle during a frame → no `fifoRead` outside FETCH, and the frame's `txOut` waveform is unchanged.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO-side controller and the serial transmit stage.
// The master side owns the FIFO flags and enable; the slave side is the transmitter.
interface fifo_uart_tx_if;
    logic       enable;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       fifoRead;
    logic       txOut;
    logic       busy;
    logic       frameDone;

    modport master (
        output enable, fifoEmpty, fifoData,
        input  fifoRead, txOut, busy, frameDone
    );

    modport slave (
        input  enable, fifoEmpty, fifoData,
        output fifoRead, txOut, busy, frameDone
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Every output is a register, so nothing on the bus depends combinationally on inputs.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_uart_tx_if.slave bus
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_read;
    logic             r_busy;
    logic             r_done;

    logic w_last;
    logic w_go;

    assign w_last = (r_cnt == CNT_LAST);
    assign w_go   = bus.enable && !bus.fifoEmpty;

    assign bus.txOut     = r_tx;
    assign bus.fifoRead  = r_read;
    assign bus.busy      = r_busy;
    assign bus.frameDone = r_done;

    // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_read  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised only by the branch that owns them.
            r_read <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state <= FETCH;
                        r_read  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: r_state <= LOAD;
                LOAD: begin
                    r_shift <= bus.fifoData;
                    r_tx    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= START;
                end
                START: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[r_bit + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_done <= 1'b1;
                        // Flags are only consulted here and in IDLE, so a burst chains with a 2-cycle gap.
                        if (w_go) begin
                            r_state <= FETCH;
                            r_read  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
